run_dispatcher: RTL



---
 rtl/merge_pkg.sv | 35 +++
 rtl/run_dispatcher.sv | 109 ++++++++++
 2 files changed

// File: rtl/merge_pkg.sv
// Shared types for the two-input merge stage: {last, data} FIFO word and dispatcher FSM states.
// The merge logic unpacks words with the same helpers used to describe the dispatcher output.
package merge_pkg;

  localparam int unsigned DFLT_DATA_WIDTH   = 32;
  localparam int unsigned DFLT_BUNDLE_WIDTH = 8;
  localparam int unsigned DFLT_BUNDLE_BITS  = DFLT_DATA_WIDTH * DFLT_BUNDLE_WIDTH;

  typedef struct packed {
    logic                        last;
    logic [DFLT_BUNDLE_BITS-1:0] data;
  } data_lt;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DISPATCH,
    RD_DONE
  } rd_state_e;

  function automatic data_lt pack_data(input logic last, input logic [DFLT_BUNDLE_BITS-1:0] data);
    data_lt w;
    w.last = last;
    w.data = data;
    return w;
  endfunction

  function automatic logic word_last(input data_lt w);
    return w.last;
  endfunction

  function automatic logic [DFLT_BUNDLE_BITS-1:0] word_data(input data_lt w);
    return w.data;
  endfunction

endpackage

// File: rtl/run_dispatcher.sv
// Cuts a bundle stream into runs of run_len bundles, alternating FIFO 0/1, tagging each run end with last.
// One-cycle registered write; ready tracks only the selected FIFO's full, so full stalls the input in place.
module run_dispatcher
  import merge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEY_WIDTH    = 32,
  parameter int unsigned BUNDLE_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [CNT_WIDTH-1:0]               i_run_len,
  input  logic [CNT_WIDTH-1:0]               i_num_runs,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_bundle,
  input  logic                               i_bundle_vld,
  output logic                               o_bundle_rdy,
  input  logic                               i_fifo_full_0,
  input  logic                               i_fifo_full_1,
  output logic [DATA_WIDTH*BUNDLE_WIDTH:0]   o_fifo_data_0,
  output logic [DATA_WIDTH*BUNDLE_WIDTH:0]   o_fifo_data_1,
  output logic                               o_fifo_write_0,
  output logic                               o_fifo_write_1,
  output logic                               o_busy,
  output logic                               o_done
);

  // Keys ride inside the record untouched; only their placement must be sane.
  if (KEY_WIDTH > DATA_WIDTH) begin : g_key_width_check
    $error("run_dispatcher: KEY_WIDTH exceeds DATA_WIDTH");
  end

  rd_state_e            state;
  logic [CNT_WIDTH-1:0] run_len_q;
  logic [CNT_WIDTH-1:0] num_runs_q;
  logic [CNT_WIDTH-1:0] bundle_cnt;
  logic [CNT_WIDTH-1:0] run_cnt;
  logic                 sel;
  logic                 xfer;
  logic                 is_last;
  logic                 last_run;

  assign o_bundle_rdy = (state == RD_DISPATCH) & ~(sel ? i_fifo_full_1 : i_fifo_full_0);
  assign xfer         = o_bundle_rdy & i_bundle_vld;
  assign is_last      = (bundle_cnt == run_len_q - CNT_WIDTH'(1));
  assign last_run     = (run_cnt == num_runs_q - CNT_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= RD_IDLE;
      run_len_q      <= '0;
      num_runs_q     <= '0;
      bundle_cnt     <= '0;
      run_cnt        <= '0;
      sel            <= 1'b0;
      o_fifo_data_0  <= '0;
      o_fifo_data_1  <= '0;
      o_fifo_write_0 <= 1'b0;
      o_fifo_write_1 <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_fifo_write_0 <= 1'b0;
      o_fifo_write_1 <= 1'b0;
      o_done         <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (i_start) begin
            run_len_q  <= i_run_len;
            num_runs_q <= i_num_runs;
            bundle_cnt <= '0;
            run_cnt    <= '0;
            sel        <= 1'b0;
            o_busy     <= 1'b1;
            state      <= (i_run_len == '0 || i_num_runs == '0) ? RD_DONE : RD_DISPATCH;
          end
        end
        RD_DISPATCH: begin
          if (xfer) begin
            if (sel) begin
              o_fifo_data_1  <= {is_last, i_bundle};
              o_fifo_write_1 <= 1'b1;
            end else begin
              o_fifo_data_0  <= {is_last, i_bundle};
              o_fifo_write_0 <= 1'b1;
            end
            // sel only moves on a bundle that actually left, so a stalled last stays on its FIFO
            if (is_last) begin
              bundle_cnt <= '0;
              run_cnt    <= run_cnt + CNT_WIDTH'(1);
              sel        <= ~sel;
              if (last_run) state <= RD_DONE;
            end else begin
              bundle_cnt <= bundle_cnt + CNT_WIDTH'(1);
            end
          end
        end
        RD_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule
